// File: rtl/nb_load_hazard_monitor_if.sv
// Remote-load request, response and pipeline-write observation bundle
// sampled by nb_load_hazard_monitor.
interface nb_load_hazard_monitor_if #(
    parameter int data_width_p     = 32,
    parameter int reg_addr_width_p = 5,
    parameter int num_rf_p         = 2
);
    localparam int rf_width_lp = (num_rf_p > 1) ? $clog2(num_rf_p) : 1;

    logic                                  req_v_i;
    logic [rf_width_lp-1:0]                req_rf_i;
    logic [reg_addr_width_p-1:0]           req_rd_i;
    logic [data_width_p-1:0]               req_pc_i;
    logic [num_rf_p-1:0]                   resp_v_i;
    logic [num_rf_p*reg_addr_width_p-1:0]  resp_rd_i;
    logic [num_rf_p-1:0]                   resp_force_i;
    logic [num_rf_p-1:0]                   resp_accept_i;
    logic [num_rf_p*2-1:0]                 pipe_wen_i;
    logic [num_rf_p*2*reg_addr_width_p-1:0] pipe_rd_i;

    modport master (
        output req_v_i, req_rf_i, req_rd_i, req_pc_i,
        output resp_v_i, resp_rd_i, resp_force_i, resp_accept_i,
        output pipe_wen_i, pipe_rd_i
    );

    modport slave (
        input req_v_i, req_rf_i, req_rd_i, req_pc_i,
        input resp_v_i, resp_rd_i, resp_force_i, resp_accept_i,
        input pipe_wen_i, pipe_rd_i
    );
endinterface

// File: rtl/nb_load_hazard_monitor.sv
// Tracks outstanding non-blocking remote loads per destination register and
// flags WAW, underflow, overflow and timeout conditions.
module nb_load_hazard_monitor #(
    parameter int data_width_p     = 32,
    parameter int reg_els_p        = 32,
    parameter int reg_addr_width_p = 5,
    parameter int num_rf_p         = 2,
    parameter int max_out_p        = 4,
    parameter int timeout_p        = 1024,
    parameter int x_cord_width_p   = 6,
    parameter int y_cord_width_p   = 5,
    parameter bit report_p         = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [x_cord_width_p-1:0]     my_x_i,
    input  logic [y_cord_width_p-1:0]     my_y_i,
    nb_load_hazard_monitor_if.slave       mon_if,
    output logic                          error_o,
    output logic [15:0]                   error_count_o,
    output logic [num_rf_p*reg_els_p-1:0] busy_o
);
    localparam int rf_width_lp = (num_rf_p > 1) ? $clog2(num_rf_p) : 1;
    localparam int cnt_w_lp    = $clog2(max_out_p + 1);
    localparam int age_w_lp    = $clog2(timeout_p + 1);
    localparam int aw_lp       = reg_addr_width_p;

    logic [cnt_w_lp-1:0]     cnt_q       [num_rf_p][reg_els_p];
    logic [cnt_w_lp-1:0]     cnt_d       [num_rf_p][reg_els_p];
    logic [age_w_lp-1:0]     age_q       [num_rf_p][reg_els_p];
    logic [age_w_lp-1:0]     age_d       [num_rf_p][reg_els_p];
    logic [data_width_p-1:0] aggr_pc_q   [num_rf_p][reg_els_p];
    logic [data_width_p-1:0] aggr_pc_d   [num_rf_p][reg_els_p];
    logic [data_width_p-1:0] victim_pc_q [num_rf_p][reg_els_p];
    logic [data_width_p-1:0] victim_pc_d [num_rf_p][reg_els_p];

    logic                    error_q, error_d;
    logic [15:0]             err_cnt_q, err_cnt_d;

    logic [aw_lp-1:0]        resp_rd [num_rf_p];
    logic [aw_lp-1:0]        tmo_rd  [num_rf_p];
    logic [num_rf_p-1:0]     cmp_v;
    logic [num_rf_p-1:0]     waw, under, tmo;
    logic                    over, err_any;
    logic                    iss, cmp, tracked;

    always_comb begin
        cnt_d       = cnt_q;
        age_d       = age_q;
        aggr_pc_d   = aggr_pc_q;
        victim_pc_d = victim_pc_q;
        waw         = '0;
        under       = '0;
        tmo         = '0;
        over        = 1'b0;
        iss         = 1'b0;
        cmp         = 1'b0;
        tracked     = 1'b0;
        for (int unsigned k = 0; k < num_rf_p; k++) begin
            resp_rd[k] = mon_if.resp_rd_i[k*aw_lp +: aw_lp];
            tmo_rd[k]  = '0;
            cmp_v[k]   = mon_if.resp_v_i[k] & (mon_if.resp_force_i[k] | mon_if.resp_accept_i[k]);
        end

        for (int unsigned k = 0; k < num_rf_p; k++) begin
            for (int unsigned s = 0; s < 2; s++) begin
                if (mon_if.resp_v_i[k] && mon_if.resp_force_i[k] && mon_if.pipe_wen_i[k*2+s]
                    && (mon_if.pipe_rd_i[(k*2+s)*aw_lp +: aw_lp] == resp_rd[k])
                    && !(k == 0 && resp_rd[k] == '0))
                    waw[k] = 1'b1;
            end
        end

        for (int unsigned k = 0; k < num_rf_p; k++) begin
            for (int unsigned r = 0; r < reg_els_p; r++) begin
                tracked = !(k == 0 && r == 0);
                iss = tracked && mon_if.req_v_i
                      && (mon_if.req_rf_i == rf_width_lp'(k))
                      && (mon_if.req_rd_i == aw_lp'(r));
                cmp = tracked && cmp_v[k] && (resp_rd[k] == aw_lp'(r));

                if (cmp && cnt_q[k][r] == '0)
                    under[k] = 1'b1;
                if (iss && !cmp && cnt_q[k][r] == cnt_w_lp'(max_out_p))
                    over = 1'b1;
                if (!cmp && cnt_q[k][r] != '0 && age_q[k][r] == age_w_lp'(timeout_p - 1)) begin
                    if (!tmo[k])
                        tmo_rd[k] = aw_lp'(r);
                    tmo[k] = 1'b1;
                end

                // Counter saturates at both ends; issue+completion cancel out.
                if (iss && !cmp) begin
                    if (cnt_q[k][r] != cnt_w_lp'(max_out_p))
                        cnt_d[k][r] = cnt_q[k][r] + cnt_w_lp'(1);
                end else if (cmp && !iss) begin
                    if (cnt_q[k][r] != '0)
                        cnt_d[k][r] = cnt_q[k][r] - cnt_w_lp'(1);
                end

                if (cmp || (iss && cnt_q[k][r] == '0))
                    age_d[k][r] = '0;
                else if (cnt_q[k][r] != '0 && age_q[k][r] != age_w_lp'(timeout_p))
                    age_d[k][r] = age_q[k][r] + age_w_lp'(1);

                if (iss)
                    aggr_pc_d[k][r] = mon_if.req_pc_i;
                if (cmp)
                    victim_pc_d[k][r] = aggr_pc_q[k][r];
            end
        end

        err_any   = (|waw) | (|under) | over | (|tmo);
        error_d   = error_q | err_any;
        err_cnt_d = (err_any && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt_q       <= '{default: '0};
            age_q       <= '{default: '0};
            aggr_pc_q   <= '{default: '0};
            victim_pc_q <= '{default: '0};
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            age_q       <= age_d;
            aggr_pc_q   <= aggr_pc_d;
            victim_pc_q <= victim_pc_d;
            error_q     <= error_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int unsigned k = 0; k < num_rf_p; k++)
            for (int unsigned r = 0; r < reg_els_p; r++)
                busy_o[k*reg_els_p + r] = (cnt_q[k][r] != '0);
    end

    assign error_o       = error_q;
    assign error_count_o = err_cnt_q;

    // Messages sampled mid-cycle so they see the same inputs the next edge will.
    if (report_p) begin : g_report
        always_ff @(negedge clk_i) begin
            if (reset_n_i) begin
                for (int unsigned k = 0; k < num_rf_p; k++) begin
                    if (waw[k])
                        $error("[%0t] x=%0d y=%0d E_WAW rf=%0d rd=%0d aggr_pc=%h victim_pc=%h: forced writeback collides with an in-flight pipeline write; apply the BSG_FIX_WAW_HAZARD software patch",
                               $time, my_x_i, my_y_i, k, resp_rd[k],
                               aggr_pc_q[k][resp_rd[k]], victim_pc_q[k][resp_rd[k]]);
                    if (under[k])
                        $error("[%0t] x=%0d y=%0d E_UNDER rf=%0d rd=%0d aggr_pc=%h victim_pc=%h: response with no outstanding load",
                               $time, my_x_i, my_y_i, k, resp_rd[k],
                               aggr_pc_q[k][resp_rd[k]], victim_pc_q[k][resp_rd[k]]);
                    if (tmo[k])
                        $error("[%0t] x=%0d y=%0d E_TIMEOUT rf=%0d rd=%0d aggr_pc=%h victim_pc=%h: load outstanding too long",
                               $time, my_x_i, my_y_i, k, tmo_rd[k],
                               aggr_pc_q[k][tmo_rd[k]], victim_pc_q[k][tmo_rd[k]]);
                end
                if (over)
                    $error("[%0t] x=%0d y=%0d E_OVER rf=%0d rd=%0d aggr_pc=%h victim_pc=%h: too many outstanding loads",
                           $time, my_x_i, my_y_i, mon_if.req_rf_i, mon_if.req_rd_i,
                           aggr_pc_q[mon_if.req_rf_i][mon_if.req_rd_i],
                           victim_pc_q[mon_if.req_rf_i][mon_if.req_rd_i]);
            end
        end
    end
endmodule

// File: tb/tb_nb_load_hazard_monitor.sv
// Directed-vector bench for nb_load_hazard_monitor with max_out_p=4, timeout_p=8.
module tb_nb_load_hazard_monitor;
    localparam int AW  = 5;
    localparam int NRF = 2;
    localparam int ELS = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [5:0]        my_x = 6'd3;
    logic [4:0]        my_y = 5'd2;
    logic              error;
    logic [15:0]       err_cnt;
    logic [NRF*ELS-1:0] busy;
    int unsigned       n_checks = 0;
    int unsigned       n_pass = 0;

    always #5 clk = ~clk;

    nb_load_hazard_monitor_if #(.data_width_p(32), .reg_addr_width_p(AW), .num_rf_p(NRF)) mif ();

    nb_load_hazard_monitor #(
        .data_width_p(32), .reg_els_p(ELS), .reg_addr_width_p(AW), .num_rf_p(NRF),
        .max_out_p(4), .timeout_p(8), .x_cord_width_p(6), .y_cord_width_p(5),
        .report_p(1'b0)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .my_x_i(my_x), .my_y_i(my_y),
        .mon_if(mif.slave),
        .error_o(error), .error_count_o(err_cnt), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mif.req_v_i       = 1'b0;
        mif.req_rf_i      = '0;
        mif.req_rd_i      = '0;
        mif.req_pc_i      = '0;
        mif.resp_v_i      = '0;
        mif.resp_rd_i     = '0;
        mif.resp_force_i  = '0;
        mif.resp_accept_i = '0;
        mif.pipe_wen_i    = '0;
        mif.pipe_rd_i     = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_issue(input int rf, input int rd, input logic [31:0] pc);
        mif.req_v_i  = 1'b1;
        mif.req_rf_i = 1'(rf);
        mif.req_rd_i = AW'(rd);
        mif.req_pc_i = pc;
    endtask

    task automatic set_resp(input int rf, input int rd, input bit force_wb);
        mif.resp_v_i[rf]           = 1'b1;
        mif.resp_rd_i[rf*AW +: AW] = AW'(rd);
        if (force_wb) mif.resp_force_i[rf]  = 1'b1;
        else          mif.resp_accept_i[rf] = 1'b1;
    endtask

    task automatic set_pipe(input int rf, input int stage, input int rd);
        mif.pipe_wen_i[rf*2+stage]              = 1'b1;
        mif.pipe_rd_i[(rf*2+stage)*AW +: AW]    = AW'(rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        do_reset();
        check("rst_error", 32'(error), 0);
        check("rst_count", 32'(err_cnt), 0);
        check("rst_busy", 32'(busy != '0), 0);

        // Accepted response three cycles after issue
        set_issue(0, 5, 32'h100); tick(); idle();
        check("t1_busy_c1", 32'(busy[5]), 1);
        tick();
        check("t1_busy_c2", 32'(busy[5]), 1);
        tick();
        check("t1_busy_c3", 32'(busy[5]), 1);
        set_resp(0, 5, 1'b0); tick(); idle();
        check("t1_busy_done", 32'(busy[5]), 0);
        check("t1_victim", dut.victim_pc_q[0][5], 32'h100);
        check("t1_error", 32'(error), 0);

        // Forced writeback: pipeline writes a different rd, then the same rd
        do_reset();
        set_issue(1, 7, 32'h200); tick(); idle();
        check("t2_busy", 32'(busy[ELS+7]), 1);
        set_resp(1, 7, 1'b1); set_pipe(1, 1, 6); tick(); idle();
        check("t2_nowaw_err", 32'(error), 0);
        check("t2_nowaw_busy", 32'(busy[ELS+7]), 0);
        set_issue(1, 7, 32'h200); tick(); idle();
        set_resp(1, 7, 1'b1); set_pipe(1, 1, 7); tick(); idle();
        check("t2_waw_err", 32'(error), 1);
        check("t2_waw_count", 32'(err_cnt), 1);
        check("t2_victim", dut.victim_pc_q[1][7], 32'h200);

        // Underflow; x0 is never tracked or flagged; f0 is tracked
        do_reset();
        set_resp(0, 9, 1'b0); tick(); idle();
        check("t3_under_err", 32'(error), 1);
        check("t3_under_count", 32'(err_cnt), 1);
        check("t3_under_busy", 32'(busy != '0), 0);
        do_reset();
        set_resp(0, 0, 1'b0); set_issue(0, 0, 32'h4); tick(); idle();
        check("t3_x0_err", 32'(error), 0);
        check("t3_x0_busy", 32'(busy[0]), 0);
        set_issue(1, 0, 32'h8); tick(); idle();
        check("t3_f0_busy", 32'(busy[ELS]), 1);

        // Overflow at the fifth issue; counter holds at max
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_issue(0, 3, 32'h300 + 32'(i)); tick();
        end
        idle();
        check("t4_four_err", 32'(error), 0);
        set_issue(0, 3, 32'h304); tick(); idle();
        check("t4_over_err", 32'(error), 1);
        check("t4_over_count", 32'(err_cnt), 1);
        set_issue(0, 3, 32'h305); set_resp(0, 3, 1'b0); tick(); idle();
        check("t4_isscmp_count", 32'(err_cnt), 1);
        for (int i = 0; i < 4; i++) begin
            set_resp(0, 3, 1'b0); tick(); idle();
            check($sformatf("t4_drain%0d_busy", i), 32'(busy[3]), (i < 3) ? 32'd1 : 32'd0);
        end
        check("t4_drain_count", 32'(err_cnt), 1);
        set_resp(0, 3, 1'b0); tick(); idle();
        check("t4_extra_under", 32'(err_cnt), 2);

        // Timeout fires once, eight edges after the issuing edge registers it
        do_reset();
        set_issue(0, 4, 32'h400); tick(); idle();
        repeat (7) tick();
        check("t5_pre_count", 32'(err_cnt), 0);
        check("t5_pre_err", 32'(error), 0);
        tick();
        check("t5_tmo_count", 32'(err_cnt), 1);
        check("t5_tmo_err", 32'(error), 1);
        repeat (5) tick();
        check("t5_once_count", 32'(err_cnt), 1);
        set_resp(0, 4, 1'b0); tick(); idle();
        check("t5_late_busy", 32'(busy[4]), 0);
        check("t5_late_count", 32'(err_cnt), 1);

        // Reset with loads outstanding drops tracking
        do_reset();
        set_issue(0, 1, 32'h10); tick();
        set_issue(0, 2, 32'h20); tick();
        set_issue(1, 2, 32'h30); tick(); idle();
        check("t6_busy_before", 32'(busy != '0), 1);
        reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
        check("t6_busy_after", 32'(busy != '0), 0);
        check("t6_err_after", 32'(error), 0);
        set_resp(0, 2, 1'b0); tick(); idle();
        check("t6_under_err", 32'(error), 1);
        check("t6_under_count", 32'(err_cnt), 1);

        // Several error classes in one cycle count once
        do_reset();
        set_resp(1, 3, 1'b1); set_pipe(1, 0, 3); set_resp(0, 9, 1'b0); tick(); idle();
        check("t7_multi_count", 32'(err_cnt), 1);
        tick();
        check("t7_quiet_count", 32'(err_cnt), 1);
        set_resp(0, 9, 1'b0); tick(); idle();
        check("t7_second_count", 32'(err_cnt), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/nb_load_hazard_monitor.md
Name: nb_load_hazard_monitor

Overview:
Parametrised testbench monitor for non-blocking remote loads in the vanilla core, generalised to N register files (int, fp, ...).
- Tracks outstanding remote loads per destination register using per-register counters and age timers.
- Flags four error classes: forced-writeback WAW against in-flight pipeline writes, response underflow, outstanding overflow, and response timeout.
- Bound into each tile next to the core; drives no design signals.

Parameters:
- data_width_p, 32, PC width.
- reg_els_p, 32, registers per register file.
- reg_addr_width_p, 5, register index width, equal to clog2(reg_els_p).
- num_rf_p, 2, number of register files (rf 0 = int, rf 1 = fp).
- max_out_p, 4, legal outstanding loads per register; counter width is clog2(max_out_p+1).
- timeout_p, 1024, cycles an outstanding load may wait before the timeout error; timeout_p >= 2.
- x_cord_width_p, 6, tile x coordinate width.
- y_cord_width_p, 5, tile y coordinate width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, synchronous, active-low
- my_x_i  in  x_cord_width_p  tile x, used in messages
- my_y_i  in  y_cord_width_p  tile y, used in messages
- req_v_i  in  1  remote load accepted by the network this cycle (v & yumi & read)
- req_rf_i  in  max(1,clog2(num_rf_p))  destination register file
- req_rd_i  in  reg_addr_width_p  destination register
- req_pc_i  in  data_width_p  PC of the issuing instruction
- resp_v_i  in  num_rf_p  load response present, per rf
- resp_rd_i  in  num_rf_p*reg_addr_width_p  response destination register, per rf
- resp_force_i  in  num_rf_p  response writes by stalling the pipeline (force writeback)
- resp_accept_i  in  num_rf_p  response written into an idle write port this cycle
- pipe_wen_i  in  num_rf_p*2  per rf: bit 0 = mem stage writes rf, bit 1 = wb stage writes rf
- pipe_rd_i  in  num_rf_p*2*reg_addr_width_p  matching rd per rf and stage
- error_o  out  1  sticky error flag
- error_count_o  out  16  cycles with at least one error; saturates at 16'hFFFF
- busy_o  out  num_rf_p*reg_els_p  bit [rf*reg_els_p+r] = cnt[rf][r] != 0

Behaviour:
Reset
- On reset_n_i == 0 at posedge, all cnt, age, aggr_pc and victim_pc clear to 0.
- error_o = 0, error_count_o = 0, busy_o = 0.
- Reset mid-operation drops all tracking. Responses arriving after reset are underflow errors.
- No error checking or reporting while reset_n_i == 0.

Per-entry state for (rf, r)
- cnt, age (clog2(timeout_p+1) bits), aggr_pc = PC of the latest issue, victim_pc = PC stamped on the latest completion.
- rf 0 register 0 is never tracked: requests to it are ignored and responses to it are never errors.

Issue and completion
- Issue: req_v_i increments cnt[req_rf_i][req_rd_i] and loads aggr_pc with req_pc_i.
- Completion for rf k: resp_v_i[k] & (resp_force_i[k] | resp_accept_i[k]) decrements cnt[k][rd] and copies aggr_pc into victim_pc.
- Issue and completion to the same entry in the same cycle: cnt unchanged, aggr_pc = req_pc_i, age reset to 0.

Age
- If cnt == 0 and an issue occurs: age <= 0.
- On any completion: age <= 0.
- Otherwise, while cnt != 0: age increments, saturating at timeout_p.

Errors (all evaluated combinationally from current state and inputs; all can fire in the same cycle)
- E_WAW[k]: resp_v_i[k] & resp_force_i[k], and for any stage s, pipe_wen_i[k][s] & pipe_rd_i[k][s] == resp_rd_i[k].
- E_UNDER[k]: completion for rf k when cnt == 0. cnt stays 0; it does not wrap.
- E_OVER: issue while cnt == max_out_p. cnt stays at max_out_p; it does not wrap. Simultaneous completion to the same entry suppresses E_OVER.
- E_TIMEOUT: age == timeout_p-1 with cnt != 0 and no completion this cycle. Fires once; the saturated age does not re-fire.

Reporting
- Any error at posedge sets error_o and adds 1 to error_count_o, regardless of how many errors occurred in that cycle.
- At negedge, one $error per asserted error class and rf.
- Each message carries $time, x, y, rf, rd, aggr_pc, victim_pc.
- The E_WAW message also directs the user to the BSG_FIX_WAW_HAZARD software patch.

Outputs
- busy_o reflects registered cnt only: it shows the post-edge value, 1-cycle latency from issue or completion.

Test Plan:
- Issue rf0 x5 pc=0x100, then accept response 3 cycles later -> busy_o[5] high for exactly 3 cycles, victim_pc[0][5]=0x100, error_o=0.
- Issue rf1 f7 pc=0x200; force response rd=7 with pipe_wen_i[1][1]=1, pipe_rd_i=7 -> E_WAW message with rd=7, aggr_pc=0x200; error_o=1; error_count_o=1.
- Response rf0 x9 with no prior issue -> E_UNDER, cnt stays 0, error_count_o=1. Response to rf0 x0 -> no error.
- Five issues to rf0 x3 with max_out_p=4 -> E_OVER on the 5th, cnt=4. Issue plus completion in the same cycle at cnt=4 -> no error, cnt=4.
- timeout_p=8: issue rf0 x4, no response -> E_TIMEOUT exactly once, 7 cycles after issue. A later response clears cnt with no further error.
- Reset asserted with 3 loads outstanding, then a response arrives after release -> busy_o=0 after reset, E_UNDER raised, error_count_o=1.
